// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and its command parser: opcodes, sync byte, error causes, parser states.
package alu_pkg;

   localparam logic [7:0] ADD = 8'd1;
   localparam logic [7:0] SUB = 8'd2;
   localparam logic [7:0] MUL = 8'd3;
   localparam logic [7:0] DIV = 8'd4;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   localparam logic [2:0] ERR_CHECKSUM = 3'd1;
   localparam logic [2:0] ERR_OPCODE   = 3'd2;
   localparam logic [2:0] ERR_DIVZERO  = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
   localparam logic [2:0] ERR_OVERRUN  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPC,
      ST_NUM1,
      ST_NUM2,
      ST_CHK,
      ST_ISSUE,
      ST_WAIT
   } parserState_t;

   function automatic logic isKnownOp(input logic [7:0] op);
      return (op == ADD) || (op == SUB) || (op == MUL) || (op == DIV);
   endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and pulses o_expire after TIMEOUT of them.
module byte_timeout #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_count;

   // Counter restarts whenever a byte arrives or the frame is not in progress; it saturates at LAST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear || !i_enable) begin
         r_count <= '0;
      end else if (r_count != LAST) begin
         r_count <= r_count + CW'(1);
      end
   end

   // TIMEOUT of zero turns the watchdog off entirely.
   assign o_expire = (TIMEOUT != 0) && i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/alu_cmd_parser.sv
// Turns the host RX byte stream into validated ALU commands: SYNC, opcode, operands, checksum.
module alu_cmd_parser
   import alu_pkg::*;
#(
   parameter int         bitness = 8,
   parameter logic [7:0] SYNC    = SYNC_DEFAULT,
   parameter int         TIMEOUT = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   input  logic               alu_done,
   output logic [bitness-1:0] num_1,
   output logic [bitness-1:0] num_2,
   output logic [7:0]         op_code,
   output logic               o_ready,
   output logic               busy,
   output logic               err,
   output logic [2:0]         err_code
);

   localparam int NB = (bitness + 7) / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

   parserState_t       r_state, w_stateNext;
   logic [bitness-1:0] r_num1, w_num1Next;
   logic [bitness-1:0] r_num2, w_num2Next;
   logic [7:0]         r_opCode, w_opCodeNext;
   logic [7:0]         r_chk, w_chkNext;
   logic [CW-1:0]      r_byteCnt, w_byteCntNext;
   logic               r_ready, w_readyNext;
   logic               r_busy, w_busyNext;
   logic               r_err, w_errNext;
   logic [2:0]         r_errCode, w_errCodeNext;
   logic               w_frameActive;
   logic               w_timeout;

   assign w_frameActive = (r_state == ST_OPC) || (r_state == ST_NUM1) ||
                          (r_state == ST_NUM2) || (r_state == ST_CHK);

   byte_timeout #(.TIMEOUT(TIMEOUT)) u_byteTimeout (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (rx_valid),
      .i_enable (w_frameActive),
      .o_expire (w_timeout)
   );

   // Next-state and registered-output logic; every output is registered so reset clears it at once.
   always_comb begin
      w_stateNext   = r_state;
      w_num1Next    = r_num1;
      w_num2Next    = r_num2;
      w_opCodeNext  = r_opCode;
      w_chkNext     = r_chk;
      w_byteCntNext = r_byteCnt;
      w_readyNext   = 1'b0;
      w_busyNext    = r_busy;
      w_errNext     = 1'b0;
      w_errCodeNext = r_errCode;

      case (r_state)
         ST_IDLE: begin
            if (rx_valid && rx_data == SYNC) begin
               w_stateNext = ST_OPC;
               w_busyNext  = 1'b1;
            end
         end
         ST_OPC: begin
            if (rx_valid) begin
               w_opCodeNext  = rx_data;
               w_chkNext     = rx_data;
               w_byteCntNext = '0;
               w_stateNext   = ST_NUM1;
            end
         end
         ST_NUM1: begin
            if (rx_valid) begin
               w_num1Next = bitness'({r_num1, rx_data});
               w_chkNext  = r_chk ^ rx_data;
               if (r_byteCnt == LAST_BYTE) begin
                  w_byteCntNext = '0;
                  w_stateNext   = ST_NUM2;
               end else begin
                  w_byteCntNext = r_byteCnt + CW'(1);
               end
            end
         end
         ST_NUM2: begin
            if (rx_valid) begin
               w_num2Next = bitness'({r_num2, rx_data});
               w_chkNext  = r_chk ^ rx_data;
               if (r_byteCnt == LAST_BYTE) begin
                  w_byteCntNext = '0;
                  w_stateNext   = ST_CHK;
               end else begin
                  w_byteCntNext = r_byteCnt + CW'(1);
               end
            end
         end
         ST_CHK: begin
            if (rx_valid) begin
               w_errNext   = 1'b1;
               w_busyNext  = 1'b0;
               w_stateNext = ST_IDLE;
               if (rx_data != r_chk) begin
                  w_errCodeNext = ERR_CHECKSUM;
               end else if (!isKnownOp(r_opCode)) begin
                  w_errCodeNext = ERR_OPCODE;
               end else if (r_opCode == DIV && r_num2 == '0) begin
                  w_errCodeNext = ERR_DIVZERO;
               end else begin
                  w_errNext   = 1'b0;
                  w_busyNext  = 1'b1;
                  w_readyNext = 1'b1;
                  w_stateNext = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            w_stateNext = ST_WAIT;
            if (rx_valid) begin
               w_errNext     = 1'b1;
               w_errCodeNext = ERR_OVERRUN;
            end
         end
         ST_WAIT: begin
            if (alu_done) begin
               w_busyNext  = 1'b0;
               w_stateNext = ST_IDLE;
               if (rx_valid && rx_data == SYNC) begin
                  w_busyNext  = 1'b1;
                  w_stateNext = ST_OPC;
               end
            end else if (rx_valid) begin
               w_errNext     = 1'b1;
               w_errCodeNext = ERR_OVERRUN;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_busyNext  = 1'b0;
         end
      endcase

      // The watchdog only fires in frame states on cycles without a byte, so it never races a parse.
      if (w_timeout) begin
         w_errNext     = 1'b1;
         w_errCodeNext = ERR_TIMEOUT;
         w_busyNext    = 1'b0;
         w_stateNext   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_num1    <= '0;
         r_num2    <= '0;
         r_opCode  <= '0;
         r_chk     <= '0;
         r_byteCnt <= '0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_errCode <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_num1    <= w_num1Next;
         r_num2    <= w_num2Next;
         r_opCode  <= w_opCodeNext;
         r_chk     <= w_chkNext;
         r_byteCnt <= w_byteCntNext;
         r_ready   <= w_readyNext;
         r_busy    <= w_busyNext;
         r_err     <= w_errNext;
         r_errCode <= w_errCodeNext;
      end
   end

   assign num_1    = r_num1;
   assign num_2    = r_num2;
   assign op_code  = r_opCode;
   assign o_ready  = r_ready;
   assign busy     = r_busy;
   assign err      = r_err;
   assign err_code = r_errCode;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Directed, table-driven bench for alu_cmd_parser with 8-bit operands and a 50-cycle byte timeout.
module tb_alu_cmd_parser;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       alu_done;
   logic [7:0] num_1;
   logic [7:0] num_2;
   logic [7:0] op_code;
   logic       o_ready;
   logic       busy;
   logic       err;
   logic [2:0] err_code;

   int         compared;
   int         mismatched;
   logic [2:0] lastCode;

   typedef struct {
      logic [39:0] frame;
      logic        expReady;
      logic        expErr;
      logic [2:0]  expCode;
      logic [7:0]  expNum1;
      logic [7:0]  expNum2;
      logic [7:0]  expOp;
   } vector_t;

   vector_t vecs [11];

   alu_cmd_parser #(.bitness(8), .SYNC(8'hA5), .TIMEOUT(50)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .alu_done (alu_done),
      .num_1    (num_1),
      .num_2    (num_2),
      .op_code  (op_code),
      .o_ready  (o_ready),
      .busy     (busy),
      .err      (err),
      .err_code (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One byte per two cycles; returns on the falling edge right after the byte was sampled.
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic applyFrame(input logic [39:0] frame);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(frame[39-8*i -: 8]);
      end
   endtask

   task automatic applyDone();
      @(negedge clk);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
   endtask

   // Called one cycle after the checksum byte: o_ready/err must be up now and gone a cycle later.
   task automatic checkFrame(input string tag, input logic expReady, input logic expErr,
                             input logic [2:0] expCode, input logic [7:0] n1,
                             input logic [7:0] n2, input logic [7:0] op);
      if (expErr) lastCode = expCode;
      checkOutput({tag, ".ready"}, o_ready, expReady);
      checkOutput({tag, ".err"}, err, expErr);
      checkOutput({tag, ".errCode"}, err_code, lastCode);
      checkOutput({tag, ".busy"}, busy, expReady);
      checkOutput({tag, ".num1"}, num_1, n1);
      checkOutput({tag, ".num2"}, num_2, n2);
      checkOutput({tag, ".op"}, op_code, op);
      @(negedge clk);
      checkOutput({tag, ".readyPulse"}, o_ready, 1'b0);
      checkOutput({tag, ".errPulse"}, err, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".num1"}, num_1, 8'h00);
      checkOutput({tag, ".num2"}, num_2, 8'h00);
      checkOutput({tag, ".op"}, op_code, 8'h00);
      checkOutput({tag, ".ready"}, o_ready, 1'b0);
      checkOutput({tag, ".busy"}, busy, 1'b0);
      checkOutput({tag, ".err"}, err, 1'b0);
      checkOutput({tag, ".errCode"}, err_code, 3'd0);
   endtask

   initial begin
      int errCycle;

      compared   = 0;
      mismatched = 0;
      lastCode   = 3'd0;
      reset      = 1'b1;
      rx_data    = 8'h00;
      rx_valid   = 1'b0;
      alu_done   = 1'b0;

      vecs[0]  = '{40'hA5_01_05_03_07, 1'b1, 1'b0, 3'd0, 8'h05, 8'h03, 8'h01};
      vecs[1]  = '{40'hA5_01_05_03_06, 1'b0, 1'b1, 3'd1, 8'h05, 8'h03, 8'h01};
      vecs[2]  = '{40'hA5_09_01_01_09, 1'b0, 1'b1, 3'd2, 8'h01, 8'h01, 8'h09};
      vecs[3]  = '{40'hA5_04_09_00_0D, 1'b0, 1'b1, 3'd3, 8'h09, 8'h00, 8'h04};
      vecs[4]  = '{40'hA5_04_09_02_0F, 1'b1, 1'b0, 3'd0, 8'h09, 8'h02, 8'h04};
      vecs[5]  = '{40'hA5_02_10_04_16, 1'b1, 1'b0, 3'd0, 8'h10, 8'h04, 8'h02};
      vecs[6]  = '{40'hA5_03_A5_A5_03, 1'b1, 1'b0, 3'd0, 8'hA5, 8'hA5, 8'h03};
      vecs[7]  = '{40'hA5_00_01_02_03, 1'b0, 1'b1, 3'd2, 8'h01, 8'h02, 8'h00};
      vecs[8]  = '{40'hA5_05_01_01_05, 1'b0, 1'b1, 3'd2, 8'h01, 8'h01, 8'h05};
      vecs[9]  = '{40'hA5_09_01_01_00, 1'b0, 1'b1, 3'd1, 8'h01, 8'h01, 8'h09};
      vecs[10] = '{40'hA5_04_09_00_00, 1'b0, 1'b1, 3'd1, 8'h09, 8'h00, 8'h04};

      #1;
      checkAllZero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int v = 0; v < 11; v++) begin
         applyFrame(vecs[v].frame);
         checkFrame($sformatf("vec%0d", v), vecs[v].expReady, vecs[v].expErr,
                    vecs[v].expCode, vecs[v].expNum1, vecs[v].expNum2, vecs[v].expOp);
         if (vecs[v].expReady) begin
            checkOutput($sformatf("vec%0d.busyWait", v), busy, 1'b1);
            applyDone();
            checkOutput($sformatf("vec%0d.busyDone", v), busy, 1'b0);
         end
      end

      // alu_done in the middle of a frame must not disturb parsing.
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyDone();
      checkOutput("doneIgnored.busy", busy, 1'b1);
      applyStimulus(8'h05);
      applyStimulus(8'h03);
      applyStimulus(8'h07);
      checkFrame("doneIgnored", 1'b1, 1'b0, 3'd0, 8'h05, 8'h03, 8'h01);
      applyDone();

      // Noise before SYNC, then a stalled frame that must time out after 50 idle cycles.
      applyStimulus(8'h3C);
      applyStimulus(8'h11);
      checkOutput("noise.busy", busy, 1'b0);
      checkOutput("noise.err", err, 1'b0);
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      errCycle = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (err && errCycle == 0) errCycle = c;
      end
      checkOutput("timeout.cycle", errCycle, 50);
      checkOutput("timeout.errCode", err_code, 3'd4);
      checkOutput("timeout.busy", busy, 1'b0);
      lastCode = 3'd4;
      applyFrame(40'hA5_01_05_03_07);
      checkFrame("afterTimeout", 1'b1, 1'b0, 3'd0, 8'h05, 8'h03, 8'h01);

      // Byte during WAIT is dropped with an overrun error; the command stays put.
      applyStimulus(8'h55);
      checkOutput("overrun.err", err, 1'b1);
      checkOutput("overrun.errCode", err_code, 3'd5);
      checkOutput("overrun.busy", busy, 1'b1);
      checkOutput("overrun.num1", num_1, 8'h05);
      checkOutput("overrun.num2", num_2, 8'h03);
      checkOutput("overrun.op", op_code, 8'h01);
      lastCode = 3'd5;

      // SYNC coincident with alu_done starts the next frame directly.
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      alu_done = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      alu_done = 1'b0;
      checkOutput("coincident.busy", busy, 1'b1);
      checkOutput("coincident.err", err, 1'b0);
      applyStimulus(8'h02);
      applyStimulus(8'h10);
      applyStimulus(8'h04);
      applyStimulus(8'h16);
      checkFrame("coincident", 1'b1, 1'b0, 3'd0, 8'h10, 8'h04, 8'h02);

      // Asynchronous reset mid-frame clears outputs before the next clock edge.
      applyDone();
      applyStimulus(8'hA5);
      applyStimulus(8'h03);
      applyStimulus(8'h07);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkAllZero("asyncReset");
      lastCode = 3'd0;
      @(negedge clk);
      reset = 1'b0;
      applyFrame(40'hA5_03_07_02_06);
      checkFrame("afterReset", 1'b1, 1'b0, 3'd0, 8'h07, 8'h02, 8'h03);
      applyDone();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
